goertzel_bin_scheduler: RTL and testbench



---
 rtl/goertzel_pkg.sv | 24 ++
 rtl/goertzel_coef_table.sv | 32 +++
 rtl/goertzel_bin_scheduler.sv | 178 +++++++++++++++++
 tb/tb_goertzel_bin_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/goertzel_pkg.sv
// Shared definitions for the Goertzel bin scheduler: default widths,
// scheduler state encoding and the nominal clocks-per-sample budget.
package goertzel_pkg;

  localparam int DEF_NUM_BINS  = 8;
  localparam int DEF_BLOCK_LEN = 2000;
  localparam int DEF_SAMPLE_W  = 32;
  localparam int DEF_COEF_W    = 18;
  localparam int DEF_POWER_W   = 64;

  // 130 MHz system clock / 1.3 MHz sample rate
  localparam int CLK_PER_SAMPLE = 100;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_e;

  // Index width that stays at least one bit wide for single-entry ranges
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/goertzel_coef_table.sv
// Per-bin coefficient register file: one synchronous write port, one
// combinational read port. Writes to addresses beyond NUM_BINS are ignored.
module goertzel_coef_table
  import goertzel_pkg::*;
#(
  parameter int NUM_BINS = DEF_NUM_BINS,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int BIN_W    = idx_w(NUM_BINS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [BIN_W-1:0]  waddr_i,
  input  logic [COEF_W-1:0] wdata_i,
  input  logic [BIN_W-1:0]  raddr_i,
  output logic [COEF_W-1:0] rdata_o
);

  logic [NUM_BINS-1:0][COEF_W-1:0] tab_q;
  logic                            wr_ok;

  assign wr_ok = we_i & ({1'b0, waddr_i} < (BIN_W+1)'(NUM_BINS));

  // Coefficient storage; a write is visible on the read port next cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      tab_q          <= '0;
    else if (wr_ok) tab_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = tab_q[raddr_i];

endmodule

// File: rtl/goertzel_bin_scheduler.sv
// Time-multiplexes one Goertzel iteration core over NUM_BINS bins: each
// accepted sample is swept across every bin, blocks of BLOCK_LEN samples are
// framed with first/last markers, and core power results are re-registered.
// Optional feature macro: GOERTZEL_SCHED_THRESH_EN adds a per-bin threshold
// detection mask (thresh / detect / detect_valid).
module goertzel_bin_scheduler
  import goertzel_pkg::*;
#(
  parameter int NUM_BINS  = DEF_NUM_BINS,
  parameter int BLOCK_LEN = DEF_BLOCK_LEN,
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int POWER_W   = DEF_POWER_W,
  localparam int BIN_W    = idx_w(NUM_BINS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                cfg_we,
  input  logic [BIN_W-1:0]    cfg_addr,
  input  logic [COEF_W-1:0]   cfg_coef,
  output logic                core_valid,
  input  logic                core_ready,
  output logic [SAMPLE_W-1:0] core_sample,
  output logic [COEF_W-1:0]   core_coef,
  output logic [BIN_W-1:0]    core_bin,
  output logic                core_first,
  output logic                core_last,
  input  logic                core_done,
  input  logic [POWER_W-1:0]  core_power,
  input  logic [BIN_W-1:0]    core_power_bin,
  output logic                out_valid,
  output logic [BIN_W-1:0]    out_bin,
  output logic [POWER_W-1:0]  out_power,
  output logic                busy,
  output logic                overrun
`ifdef GOERTZEL_SCHED_THRESH_EN
  , input  logic [POWER_W-1:0]  thresh
  , output logic [NUM_BINS-1:0] detect
  , output logic                detect_valid
`endif
);

  localparam int CNT_W = idx_w(BLOCK_LEN);

  sched_state_e        state_q, state_d;
  logic [BIN_W-1:0]    bin_cnt_q, bin_cnt_d;
  logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                overrun_q, overrun_d;
  logic                out_valid_q;
  logic [BIN_W-1:0]    out_bin_q;
  logic [POWER_W-1:0]  out_power_q;

  logic issue, hs, last_bin, blk_first, blk_last, start;

  assign issue     = (state_q == ISSUE);
  assign hs        = issue & core_ready;
  assign last_bin  = (bin_cnt_q == BIN_W'(NUM_BINS - 1));
  assign blk_first = (sample_cnt_q == '0);
  assign blk_last  = (sample_cnt_q == CNT_W'(BLOCK_LEN - 1));
  // A disabled scheduler still finishes a partially processed block
  assign start     = ~issue & sample_valid & (enable | ~blk_first);

  goertzel_coef_table #(
    .NUM_BINS (NUM_BINS),
    .COEF_W   (COEF_W),
    .BIN_W    (BIN_W)
  ) u_coef (
    .clk_i   (clock),
    .rst_i   (reset),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_coef),
    .raddr_i (bin_cnt_q),
    .rdata_o (core_coef)
  );

  // Next-state: sample acceptance, bin sweep, block position, overrun capture
  always_comb begin
    state_d      = state_q;
    bin_cnt_d    = bin_cnt_q;
    sample_cnt_d = sample_cnt_q;
    sample_d     = sample_q;
    overrun_d    = overrun_q;
    if (start) begin
      state_d   = ISSUE;
      bin_cnt_d = '0;
      sample_d  = sample;
    end
    // Any strobe during a sweep (including its final handshake cycle) is lost
    if (issue & sample_valid) overrun_d = 1'b1;
    if (hs) begin
      if (last_bin) begin
        state_d      = IDLE;
        sample_cnt_d = blk_last ? '0 : sample_cnt_q + 1'b1;
      end else begin
        bin_cnt_d = bin_cnt_q + 1'b1;
      end
    end
  end

  // Scheduler state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bin_cnt_q    <= '0;
      sample_cnt_q <= '0;
      sample_q     <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_cnt_q    <= bin_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      sample_q     <= sample_d;
      overrun_q    <= overrun_d;
    end
  end

  // One-cycle re-registration of core results, independent of the sweep
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_power_q <= '0;
    end else begin
      out_valid_q <= core_done;
      out_bin_q   <= core_power_bin;
      out_power_q <= core_power;
    end
  end

  assign core_valid  = issue;
  assign core_bin    = bin_cnt_q;
  assign core_sample = sample_q;
  assign core_first  = issue & blk_first;
  assign core_last   = issue & blk_last;
  assign busy        = issue;
  assign overrun     = overrun_q;
  assign out_valid   = out_valid_q;
  assign out_bin     = out_bin_q;
  assign out_power   = out_power_q;

`ifdef GOERTZEL_SCHED_THRESH_EN
  logic [NUM_BINS-1:0] shadow_q, shadow_d;
  logic [NUM_BINS-1:0] detect_q;
  logic                detect_valid_q;
  logic                res_in_range, res_last;

  assign res_in_range = ({1'b0, core_power_bin} < (BIN_W+1)'(NUM_BINS));
  assign res_last     = core_done & (core_power_bin == BIN_W'(NUM_BINS - 1));

  // Shadow mask collects per-bin threshold decisions as results arrive
  always_comb begin
    shadow_d = shadow_q;
    if (core_done & res_in_range) shadow_d[core_power_bin] = (core_power >= thresh);
  end

  // Publish the completed mask when the last bin's result lands
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q       <= '0;
      detect_q       <= '0;
      detect_valid_q <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      detect_valid_q <= res_last;
      if (res_last) detect_q <= shadow_d;
    end
  end

  assign detect       = detect_q;
  assign detect_valid = detect_valid_q;
`endif

endmodule

// File: tb/tb_goertzel_bin_scheduler.sv
// Randomized + directed bench for goertzel_bin_scheduler. A transaction-level
// model (sweep in progress, next bin, block position, coefficient array) is
// compared against the DUT on every falling edge; directed literal checks pin
// the model on the documented scenarios.
module tb_goertzel_bin_scheduler;
  localparam int NB = 8, BL = 4, SW = 32, CW = 18, PW = 64, BW = 3;

  logic          clock = 1'b0, reset = 1'b1, enable = 1'b1;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample = '0;
  logic          cfg_we = 1'b0;
  logic [BW-1:0] cfg_addr = '0;
  logic [CW-1:0] cfg_coef = '0;
  logic          core_ready = 1'b1, core_done = 1'b0;
  logic [PW-1:0] core_power = '0;
  logic [BW-1:0] core_power_bin = '0;
  logic          core_valid, core_first, core_last, out_valid, busy, overrun;
  logic [SW-1:0] core_sample;
  logic [CW-1:0] core_coef;
  logic [BW-1:0] core_bin, out_bin;
  logic [PW-1:0] out_power;
`ifdef GOERTZEL_SCHED_THRESH_EN
  logic [PW-1:0] thresh = '0;
  logic [NB-1:0] detect;
  logic          detect_valid;
`endif

  goertzel_bin_scheduler #(.NUM_BINS(NB), .BLOCK_LEN(BL), .SAMPLE_W(SW),
                           .COEF_W(CW), .POWER_W(PW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .sample_valid(sample_valid), .sample(sample),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_coef(cfg_coef),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_sample(core_sample), .core_coef(core_coef), .core_bin(core_bin),
    .core_first(core_first), .core_last(core_last),
    .core_done(core_done), .core_power(core_power),
    .core_power_bin(core_power_bin),
    .out_valid(out_valid), .out_bin(out_bin), .out_power(out_power),
    .busy(busy), .overrun(overrun)
`ifdef GOERTZEL_SCHED_THRESH_EN
    , .thresh(thresh), .detect(detect), .detect_valid(detect_valid)
`endif
  );

  always #5 clock = ~clock;

  int n_err = 0, n_chk = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int            bin;
    logic [CW-1:0] coef;
    bit            first;
    bit            last;
    logic [SW-1:0] smp;
  } iss_t;
  iss_t log_q[$];

  bit            m_busy, m_ovr, m_outv;
  int            m_bin, m_pos, m_outbin;
  logic [SW-1:0] m_sample;
  logic [CW-1:0] m_coef [NB];
  logic [PW-1:0] m_outpow;
  logic [NB-1:0] m_shadow, m_detect;
  bit            m_dv;

  always @(negedge clock) begin
    bit was_busy;
    if (reset) begin
      m_busy = 0; m_ovr = 0; m_outv = 0; m_bin = 0; m_pos = 0; m_outbin = 0;
      m_sample = '0; m_outpow = '0; m_shadow = '0; m_detect = '0; m_dv = 0;
      for (int i = 0; i < NB; i++) m_coef[i] = '0;
      chk("rst core_first", core_first, 0);
      chk("rst core_last", core_last, 0);
      chk("rst core_bin", core_bin, 0);
      chk("rst out_power", out_power, 0);
    end
    chk("busy", busy, m_busy);
    chk("core_valid", core_valid, m_busy);
    chk("overrun", overrun, m_ovr);
    chk("out_valid", out_valid, m_outv);
    if (m_busy) begin
      chk("core_bin", core_bin, m_bin);
      chk("core_sample", core_sample, m_sample);
      chk("core_coef", core_coef, m_coef[m_bin]);
      chk("core_first", core_first, m_pos == 0);
      chk("core_last", core_last, m_pos == BL - 1);
    end
    if (m_outv) begin
      chk("out_bin", out_bin, m_outbin);
      chk("out_power", out_power, m_outpow);
    end
`ifdef GOERTZEL_SCHED_THRESH_EN
    chk("detect", detect, m_detect);
    chk("detect_valid", detect_valid, m_dv);
`endif
    if (!reset) begin
      // events of the coming rising edge
      was_busy = m_busy;
      if (sample_valid) begin
        if (was_busy) m_ovr = 1;
        else if (enable || m_pos != 0) begin
          m_busy = 1; m_bin = 0; m_sample = sample;
        end
      end
      if (was_busy && core_ready) begin
        log_q.push_back('{m_bin, core_coef, core_first, core_last, core_sample});
        if (m_bin == NB - 1) begin
          m_busy = 0;
          m_pos  = (m_pos + 1) % BL;
        end else m_bin++;
      end
      if (cfg_we) m_coef[cfg_addr] = cfg_coef;
      m_outv = core_done;
      if (core_done) begin m_outbin = core_power_bin; m_outpow = core_power; end
`ifdef GOERTZEL_SCHED_THRESH_EN
      m_dv = 0;
      if (core_done) begin
        m_shadow[core_power_bin] = (core_power >= thresh);
        if (core_power_bin == NB - 1) begin m_detect = m_shadow; m_dv = 1; end
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock); #1;
      sample_valid = 0; cfg_we = 0; core_done = 0;
    end
  endtask

  task automatic strobe(input logic [SW-1:0] v);
    sample = v; sample_valid = 1; tick(1);
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin tick(1); n++; end
    if (busy) begin
      n_chk++; n_err++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
    end
  endtask

  initial begin
    int n, gap;
    logic [CW-1:0] ec;
    tick(3);
    chk("reset core_valid", core_valid, 0);
    chk("reset overrun", overrun, 0);
    reset = 0; tick(1);

    // basic sweep with distinct coefficients
    for (int i = 0; i < NB; i++) begin
      cfg_we = 1; cfg_addr = BW'(i); cfg_coef = 18'h0A000 + CW'(i); tick(1);
    end
    log_q.delete();
    strobe(32'h0000_1234);
    wait_idle(50, n);
    chk("sweep1 length", n, NB);
    chk("sweep1 count", log_q.size(), NB);
    foreach (log_q[i]) begin
      ec = 18'h0A000 + CW'(i);
      chk("sweep1 bin", log_q[i].bin, i);
      chk("sweep1 coef", log_q[i].coef, ec);
      chk("sweep1 first", log_q[i].first, 1);
      chk("sweep1 sample", log_q[i].smp, 32'h1234);
    end

    // backpressure on bin 3 with a coefficient rewrite during the stall
    log_q.delete();
    strobe(32'h0000_5555);
    tick(3);
    chk("bp bin", core_bin, 3);
    core_ready = 0; cfg_we = 1; cfg_addr = 3'd3; cfg_coef = 18'h1F003;
    tick(1);
    chk("bp coef update", core_coef, 18'h1F003);
    tick(4);
    chk("bp bin held", core_bin, 3);
    core_ready = 1;
    wait_idle(50, n);
    chk("bp tail length", n, 5);
    chk("bp count", log_q.size(), NB);
    foreach (log_q[i]) chk("bp bin order", log_q[i].bin, i);
    if (log_q.size() > 3) chk("bp accepted coef", log_q[3].coef, 18'h1F003);

    // block framing
    reset = 1; tick(2); reset = 0; tick(1);
    enable = 0; strobe(32'h77);
    chk("disabled no start", busy, 0);
    enable = 1;
    for (int k = 0; k < 8; k++) begin
      log_q.delete();
      strobe(SW'(k + 32'h100));
      wait_idle(50, n);
      chk("frame count", log_q.size(), NB);
      if (log_q.size() > 0) begin
        chk("frame first", log_q[0].first, (k % BL) == 0);
        chk("frame last", log_q[0].last, (k % BL) == BL - 1);
      end
      tick(goertzel_pkg::CLK_PER_SAMPLE - 1 - n);
    end

    // overrun: second strobe four cycles into a sweep
    chk("overrun clear", overrun, 0);
    strobe(32'hA);
    tick(3);
    strobe(32'hB);
    chk("overrun set", overrun, 1);
    wait_idle(50, n);
    tick(5);
    chk("overrun no restart", busy, 0);
    strobe(32'hC);
    chk("third core_first", core_first, 0);
    chk("third sample", core_sample, 32'hC);
    wait_idle(50, n);

    // reset mid-sweep
    strobe(32'hD);
    tick(5);
    chk("pre-reset bin", core_bin, 5);
    reset = 1; #1;
    chk("reset core_valid drop", core_valid, 0);
    tick(2); reset = 0; tick(1);
    chk("post-reset overrun", overrun, 0);
    strobe(32'hE);
    chk("post-reset valid", core_valid, 1);
    chk("post-reset bin", core_bin, 0);
    chk("post-reset first", core_first, 1);
    wait_idle(50, n);

    // result passthrough
    core_done = 1; core_power_bin = 3'd5; core_power = 64'hDEAD_BEEF_0000_0001;
    tick(1);
    chk("pass out_valid", out_valid, 1);
    chk("pass out_bin", out_bin, 5);
    chk("pass out_power", out_power, 64'hDEAD_BEEF_0000_0001);
    tick(1);
    chk("pass out_valid drop", out_valid, 0);

`ifdef GOERTZEL_SCHED_THRESH_EN
    thresh = 64'd1000;
    for (int b = 0; b < NB; b++) begin
      core_done = 1; core_power_bin = BW'(b);
      core_power = (b == 0) ? 64'd999 : (b == 1) ? 64'd1000 : (b == 2) ? 64'd5000 : 64'd0;
      tick(1);
      if (b < NB - 1) chk("thr no early pulse", detect_valid, 0);
    end
    chk("thr detect", detect, 8'b0000_0110);
    chk("thr pulse", detect_valid, 1);
    tick(1);
    chk("thr pulse single", detect_valid, 0);
`endif

    // randomized traffic
    gap = 10;
    for (int c = 0; c < 3000; c++) begin
      core_ready = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) begin
        cfg_we = 1; cfg_addr = BW'($urandom_range(0, NB - 1)); cfg_coef = CW'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        core_done = 1; core_power_bin = BW'($urandom_range(0, NB - 1));
        core_power = {$urandom, $urandom};
      end
`ifdef GOERTZEL_SCHED_THRESH_EN
      if ($urandom_range(0, 99) == 0) thresh = {$urandom, $urandom};
`endif
      if (gap == 0) begin
        sample = $urandom; sample_valid = 1; gap = $urandom_range(5, 40);
      end else gap--;
      tick(1);
    end
    reset = 0; enable = 1; core_ready = 1;
    tick(1);
    wait_idle(100, n);
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
